// File: rtl/sound_pkg.sv
// Shared tone codes, FSM/event enums, melody ROMs and the tone half-period helper.
// Pure constants and functions; no state.
package sound_pkg;

   localparam logic [2:0] TONE_0    = 3'd0;
   localparam logic [2:0] TONE_1    = 3'd1;
   localparam logic [2:0] TONE_2    = 3'd2;
   localparam logic [2:0] TONE_3    = 3'd3;
   localparam logic [2:0] TONE_RAZZ = 3'd4;
   localparam logic [2:0] TONE_REST = 3'd5;
   localparam logic [2:0] TONE_IDLE = 3'd7;

   typedef enum logic [1:0] {ST_IDLE, ST_LAMP, ST_MELODY} state_e;

   // Encoded so that a larger value means a higher-priority event.
   typedef enum logic [1:0] {
      EVT_NONE = 2'd0,
      EVT_HS   = 2'd1,
      EVT_WIN  = 2'd2,
      EVT_LOSE = 2'd3
   } evt_e;

   // Note 0 sits in the least significant tone slot.
   localparam logic [11:0] MEL_WIN  = {TONE_0, TONE_1, TONE_2, TONE_3};
   localparam logic [11:0] MEL_LOSE = {TONE_RAZZ, TONE_RAZZ, TONE_RAZZ, TONE_RAZZ};
   localparam logic [11:0] MEL_HS   = {TONE_REST, TONE_0, TONE_REST, TONE_0};

   function automatic int half_period(input int clk_freq, input logic [2:0] code);
      int h;
      case (code)
         TONE_0:    h = clk_freq / 830;
         TONE_1:    h = clk_freq / 620;
         TONE_2:    h = clk_freq / 504;
         TONE_3:    h = clk_freq / 418;
         TONE_RAZZ: h = clk_freq / 84;
         default:   h = 1;
      endcase
      if (h < 1) h = 1;
      return h;
   endfunction

   function automatic logic [2:0] melody_tone(input evt_e evt, input logic [1:0] note);
      logic [11:0] rom;
      case (evt)
         EVT_WIN:  rom = MEL_WIN;
         EVT_LOSE: rom = MEL_LOSE;
         EVT_HS:   rom = MEL_HS;
         default:  rom = {4{TONE_IDLE}};
      endcase
      return rom[int'(note) * 3 +: 3];
   endfunction

endpackage

// File: rtl/tone_div.sv
// Programmable half-period divider: counts 0..half-1, toggles spkr at half-1 and wraps.
// spkr first rises half cycles after a clear; clr or !run hold the counter and spkr at 0.
module tone_div #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         run,
   input  logic [W-1:0] half,
   output logic         spkr
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         spkr_q, spkr_d;

   always_comb begin
      cnt_d  = cnt_q;
      spkr_d = spkr_q;
      if (clr || !run) begin
         cnt_d  = '0;
         spkr_d = 1'b0;
      end else if (cnt_q == half - W'(1)) begin
         cnt_d  = '0;
         spkr_d = ~spkr_q;
      end else begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         spkr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         spkr_q <= spkr_d;
      end
   end

   assign spkr = spkr_q;

endmodule

// File: rtl/sound_gen.sv
// Game sound generator: lamp tones plus WIN/LOSE/HS melodies; event edges act one clock after sampling.
// TONE/BUSY are registered; the speaker divider restarts from 0 whenever TONE changes.
module sound_gen
   import sound_pkg::*;
#(
   parameter int CLK_FREQ    = 50_000_000,
   parameter int NOTE_CYCLES = 7_500_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] LAMP,
   input  logic       LAMP_ENA,
   input  logic       WIN,
   input  logic       LOSE,
   input  logic       HS,
   output logic       SPKR,
   output logic       BUSY,
   output logic [2:0] TONE
);

   localparam int HALF_0    = half_period(CLK_FREQ, TONE_0);
   localparam int HALF_1    = half_period(CLK_FREQ, TONE_1);
   localparam int HALF_2    = half_period(CLK_FREQ, TONE_2);
   localparam int HALF_3    = half_period(CLK_FREQ, TONE_3);
   localparam int HALF_RAZZ = half_period(CLK_FREQ, TONE_RAZZ);
   localparam int DIV_W     = $clog2(HALF_RAZZ + 1);
   localparam int NOTE_W    = $clog2(NOTE_CYCLES + 1);

   state_e             state_q, state_d;
   evt_e               evt_q, evt_d, evt_edge;
   logic [1:0]         note_q, note_d;
   logic [NOTE_W-1:0]  ncnt_q, ncnt_d;
   logic [2:0]         tone_q, tone_d;
   logic               win_q, win_d, lose_q, lose_d, hs_q, hs_d;
   logic [DIV_W-1:0]   half_w;
   logic               tone_run, tone_clr;

   always_comb begin
      win_d  = WIN;
      lose_d = LOSE;
      hs_d   = HS;

      evt_edge = EVT_NONE;
      if (HS && !hs_q)     evt_edge = EVT_HS;
      if (WIN && !win_q)   evt_edge = EVT_WIN;
      if (LOSE && !lose_q) evt_edge = EVT_LOSE;

      state_d = state_q;
      evt_d   = evt_q;
      note_d  = note_q;
      ncnt_d  = ncnt_q;

      // evt_q is EVT_NONE outside a melody, so any edge starts one from IDLE/LAMP.
      if (evt_edge > evt_q) begin
         state_d = ST_MELODY;
         evt_d   = evt_edge;
         note_d  = 2'd0;
         ncnt_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: if (LAMP_ENA) state_d = ST_LAMP;
            ST_LAMP: if (!LAMP_ENA) state_d = ST_IDLE;
            ST_MELODY: begin
               if (ncnt_q == NOTE_W'(NOTE_CYCLES - 1)) begin
                  ncnt_d = '0;
                  if (note_q == 2'd3) begin
                     state_d = LAMP_ENA ? ST_LAMP : ST_IDLE;
                     evt_d   = EVT_NONE;
                     note_d  = 2'd0;
                  end else begin
                     note_d = note_q + 2'd1;
                  end
               end else begin
                  ncnt_d = ncnt_q + NOTE_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      case (state_d)
         ST_LAMP:   tone_d = {1'b0, LAMP};
         ST_MELODY: tone_d = melody_tone(evt_d, note_d);
         default:   tone_d = TONE_IDLE;
      endcase

      tone_clr = (tone_d != tone_q);
      tone_run = (tone_q <= TONE_RAZZ);

      case (tone_q)
         TONE_0:    half_w = DIV_W'(HALF_0);
         TONE_1:    half_w = DIV_W'(HALF_1);
         TONE_2:    half_w = DIV_W'(HALF_2);
         TONE_3:    half_w = DIV_W'(HALF_3);
         TONE_RAZZ: half_w = DIV_W'(HALF_RAZZ);
         default:   half_w = DIV_W'(1);
      endcase
   end

   // Edge registers track the inputs through reset so held levels never fire.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         evt_q   <= EVT_NONE;
         note_q  <= 2'd0;
         ncnt_q  <= '0;
         tone_q  <= TONE_IDLE;
         win_q   <= WIN;
         lose_q  <= LOSE;
         hs_q    <= HS;
      end else begin
         state_q <= state_d;
         evt_q   <= evt_d;
         note_q  <= note_d;
         ncnt_q  <= ncnt_d;
         tone_q  <= tone_d;
         win_q   <= win_d;
         lose_q  <= lose_d;
         hs_q    <= hs_d;
      end
   end

   tone_div #(.W(DIV_W)) u_tone_div (
      .clk  (CLK),
      .rst  (RST),
      .clr  (tone_clr),
      .run  (tone_run),
      .half (half_w),
      .spkr (SPKR)
   );

   assign BUSY = (state_q == ST_MELODY);
   assign TONE = tone_q;

endmodule

// File: tb/tb_sound_gen.sv
// Directed bench for sound_gen at CLK_FREQ=8300 (half-periods 10/13/16/19/98) and 200-cycle notes.
module tb_sound_gen;

   logic       CLK = 1'b0;
   logic       RST;
   logic [1:0] LAMP;
   logic       LAMP_ENA, WIN, LOSE, HS;
   logic       SPKR, BUSY;
   logic [2:0] TONE;

   int n_chk  = 0;
   int n_pass = 0;

   sound_gen #(.CLK_FREQ(8300), .NOTE_CYCLES(200)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .LAMP     (LAMP),
      .LAMP_ENA (LAMP_ENA),
      .WIN      (WIN),
      .LOSE     (LOSE),
      .HS       (HS),
      .SPKR     (SPKR),
      .BUSY     (BUSY),
      .TONE     (TONE)
   );

   always #5 CLK = ~CLK;

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      RST = 1'b1; WIN = 1'b1; LOSE = 1'b0; HS = 1'b0; LAMP = 2'd0; LAMP_ENA = 1'b0;
      step(3);
      chk("rst_spkr", SPKR, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_tone", TONE, 7);
      RST = 1'b0;
      step(5);
      chk("rst_held_win_busy", BUSY, 0);
      chk("rst_held_win_tone", TONE, 7);
      WIN = 1'b0;
      step(2);

      // Lamp 0: half-period 10
      LAMP = 2'd0; LAMP_ENA = 1'b1;
      step(1);
      chk("lamp0_tone", TONE, 0);
      chk("lamp0_spkr_entry", SPKR, 0);
      step(9);  chk("lamp0_spkr_9", SPKR, 0);
      step(1);  chk("lamp0_rise_10", SPKR, 1);
      step(9);  chk("lamp0_spkr_19", SPKR, 1);
      step(1);  chk("lamp0_fall_20", SPKR, 0);
      step(10); chk("lamp0_rise_30", SPKR, 1);
      LAMP_ENA = 1'b0;
      step(1);
      chk("lamp_off_spkr", SPKR, 0);
      chk("lamp_off_tone", TONE, 7);

      // Lamp code change mid-tone clears the divider
      LAMP = 2'd1; LAMP_ENA = 1'b1;
      step(1);  chk("lamp1_tone", TONE, 1);
      step(13); chk("lamp1_rise_13", SPKR, 1);
      LAMP = 2'd3;
      step(1);
      chk("lamp3_tone", TONE, 3);
      chk("lamp3_cleared", SPKR, 0);
      step(18); chk("lamp3_spkr_18", SPKR, 0);
      step(1);  chk("lamp3_rise_19", SPKR, 1);
      LAMP_ENA = 1'b0;
      step(2);

      // WIN melody 3,2,1,0
      chk("win_pre_busy", BUSY, 0);
      WIN = 1'b1;
      step(1);
      chk("win_n0_busy", BUSY, 1);
      chk("win_n0_tone", TONE, 3);
      step(18);  chk("win_n0_spkr_18", SPKR, 0);
      step(1);   chk("win_n0_rise_19", SPKR, 1);
      step(181); chk("win_n1_tone", TONE, 2);
      chk("win_n1_spkr_entry", SPKR, 0);
      step(16);  chk("win_n1_rise_16", SPKR, 1);
      step(184); chk("win_n2_tone", TONE, 1);
      step(13);  chk("win_n2_rise_13", SPKR, 1);
      step(187); chk("win_n3_tone", TONE, 0);
      step(10);  chk("win_n3_rise_10", SPKR, 1);
      step(189); chk("win_busy_799", BUSY, 1);
      step(1);
      chk("win_busy_800", BUSY, 0);
      chk("win_end_tone", TONE, 7);
      chk("win_end_spkr", SPKR, 0);
      WIN = 1'b0;
      step(2);

      // LOSE preempts WIN in note 2; HS during LOSE is ignored
      WIN = 1'b1;
      step(1);
      step(400); chk("pre_win_n2_tone", TONE, 1);
      step(50);
      LOSE = 1'b1;
      step(1);
      chk("lose_tone", TONE, 4);
      chk("lose_busy", BUSY, 1);
      chk("lose_spkr_entry", SPKR, 0);
      step(97); chk("lose_spkr_97", SPKR, 0);
      step(1);  chk("lose_rise_98", SPKR, 1);
      HS = 1'b1;
      step(1);  chk("lose_hs_ignored", TONE, 4);
      step(700);
      chk("lose_busy_799", BUSY, 1);
      chk("lose_n3_tone", TONE, 4);
      step(1);
      chk("lose_busy_800", BUSY, 0);
      chk("lose_end_tone", TONE, 7);
      WIN = 1'b0; LOSE = 1'b0; HS = 1'b0;
      step(2);

      // HS melody 0,rest,0,rest
      HS = 1'b1;
      step(1);
      chk("hs_n0_tone", TONE, 0);
      step(10);  chk("hs_n0_rise_10", SPKR, 1);
      step(190);
      chk("hs_n1_tone", TONE, 5);
      chk("hs_n1_spkr", SPKR, 0);
      step(15);  chk("hs_n1_spkr_mid", SPKR, 0);
      step(185);
      chk("hs_n2_tone", TONE, 0);
      chk("hs_n2_spkr_entry", SPKR, 0);
      step(10);  chk("hs_n2_rise_10", SPKR, 1);
      step(190);
      chk("hs_n3_tone", TONE, 5);
      chk("hs_n3_spkr", SPKR, 0);
      step(200); chk("hs_end_busy", BUSY, 0);
      HS = 1'b0;
      step(2);

      // Lamp held through a melody, WIN edge beats the lamp
      LAMP = 2'd2; LAMP_ENA = 1'b1; WIN = 1'b1;
      step(1);
      chk("lm_busy", BUSY, 1);
      chk("lm_tone", TONE, 3);
      step(799);
      chk("lm_busy_799", BUSY, 1);
      chk("lm_tone_799", TONE, 0);
      step(1);
      chk("lm_busy_800", BUSY, 0);
      chk("lm_lamp_tone", TONE, 2);
      chk("lm_lamp_spkr", SPKR, 0);
      step(16); chk("lm_lamp_rise_16", SPKR, 1);
      LAMP_ENA = 1'b0; WIN = 1'b0;
      step(2);

      // Simultaneous WIN+HS edges resolve to WIN; reset aborts it
      WIN = 1'b1; HS = 1'b1;
      step(1);
      chk("sim_tone", TONE, 3);
      step(19); chk("sim_rise_19", SPKR, 1);
      RST = 1'b1;
      step(1);
      chk("abort_busy", BUSY, 0);
      chk("abort_spkr", SPKR, 0);
      chk("abort_tone", TONE, 7);
      RST = 1'b0;
      step(3);
      chk("abort_no_retrigger", BUSY, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sound_gen.md
SOUND_GEN -- requirements
Module: sound_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, clock frequency in Hz used to derive tone half-periods.
REQ-002 SHALL have parameter NOTE_CYCLES, default 7_500_000, the duration of one melody note in clock cycles.
REQ-003 SHALL have port CLK input 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port RST input 1: reset, synchronous and active-high.
REQ-005 SHALL have port LAMP input 2: index of the lamp currently lit by the game controller.
REQ-006 SHALL have port LAMP_ENA input 1: high while the lamp is lit.
REQ-007 SHALL have ports WIN, LOSE and HS, each input 1: game-event levels from the controller, acted on at the rising edge.
REQ-008 SHALL have port SPKR output 1: square-wave speaker drive.
REQ-009 SHALL have port BUSY output 1: high while a melody is playing.
REQ-010 SHALL have port TONE output 3: active tone code, for debug.

Function
REQ-011 SHALL use these tone codes and half-period counts, each floored and clamped to at least 1:
- code 0: CLK_FREQ/830 (415 Hz)
- code 1: CLK_FREQ/620 (310 Hz)
- code 2: CLK_FREQ/504 (252 Hz)
- code 3: CLK_FREQ/418 (209 Hz)
- code 4: CLK_FREQ/84 (42 Hz razz)
- code 5: rest (SPKR held 0)
- code 7: idle
REQ-012 SHALL implement the state machine IDLE, LAMP, MELODY, with a 2-bit note index and a note-length counter.
REQ-013 SHALL register WIN, LOSE and HS and detect rising edges; an edge sampled in cycle n takes effect at clock edge n+1.
REQ-014 SHALL apply event priority LOSE > WIN > HS > lamp.
REQ-015 SHALL, on an event edge, enter MELODY with note 0 and load that event's melody:
- WIN: 3,2,1,0
- LOSE: 4,4,4,4
- HS: 0,5,0,5
REQ-016 SHALL, in MELODY, advance the note every NOTE_CYCLES cycles and return after note 3 to LAMP if LAMP_ENA=1, otherwise to IDLE.
REQ-017 SHALL make a melody play for exactly 4*NOTE_CYCLES cycles, with BUSY high for exactly those cycles.
REQ-018 SHALL restart MELODY at note 0 with the new melody when a higher-priority event edge arrives during a melody.
REQ-019 SHALL ignore equal- or lower-priority event edges arriving during a melody.
REQ-020 SHALL resolve simultaneous event edges by priority.
REQ-021 SHALL go from IDLE to LAMP when LAMP_ENA=1, with TONE equal to LAMP.
REQ-022 SHALL go from LAMP to IDLE when LAMP_ENA=0, with SPKR 0 from the next cycle.
REQ-023 SHALL ignore LAMP_ENA while in MELODY.
REQ-024 SHALL, whenever TONE changes (including a LAMP change mid-tone), clear the divider counter and SPKR to 0.
REQ-025 SHALL run the divider counter 0..HALF-1; at HALF-1 it toggles SPKR and wraps, so the first rising edge of SPKR occurs HALF cycles after tone entry and the period is 2*HALF.
REQ-026 SHALL hold SPKR at 0 in IDLE and during rests.
REQ-027 SHALL size its counters from the parameters: the divider to hold CLK_FREQ/84 and the note counter to hold NOTE_CYCLES; no counter overflow is permitted.

Reset
REQ-028 SHALL, while RST=1, force state IDLE, SPKR=0, BUSY=0, TONE=7, and all counters to 0.
REQ-029 SHALL load the edge-detect registers with the current WIN/LOSE/HS values during reset, so a level held through reset does not trigger a melody.
REQ-030 SHALL, on reset mid-melody, abort the melody immediately and silence the output on the next edge.

Structure
REQ-031 SHALL take the following from a shared package sound_pkg:
- tone-code constants
- state enum
- melody ROM constants
- half-period function of CLK_FREQ
REQ-032 SHALL instantiate one sub-module, tone_div: a programmable half-period divider with synchronous clear, producing SPKR.

Verification
REQ-033 SHALL cover reset: CLK_FREQ=8300, NOTE_CYCLES=200, RST=1 for 3 cycles with WIN=1 held -> SPKR=0, BUSY=0, TONE=7, and no melody after release.
REQ-034 SHALL cover a lamp tone: LAMP_ENA=1, LAMP=0 -> TONE=0, first SPKR rise 10 cycles after entry, period 20 cycles; drop LAMP_ENA -> SPKR=0 next cycle.
REQ-035 SHALL cover the WIN melody: WIN 0->1 -> BUSY high for 800 cycles, half-periods 19,16,13,10 in successive 200-cycle notes, then IDLE.
REQ-036 SHALL cover preemption: LOSE edge during WIN note 2 -> restart with half-period 98 for 800 cycles; an HS edge during LOSE is ignored.
REQ-037 SHALL cover the HS melody: HS edge -> SPKR toggles with half-period 10 in notes 0 and 2 and is held 0 in notes 1 and 3.
REQ-038 SHALL cover lamp during melody: LAMP_ENA=1 throughout a melody -> no lamp tone while BUSY; the lamp tone starts the cycle after BUSY falls.
